// File: rtl/sprite_rom_arbiter_if.sv
// ============================================================================
// Module : sprite_rom_arbiter_if
// Brief  : Requester-side handshake and response bundle for the sprite ROM
//          arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_burst;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  // Requester side
  modport master (
    output req_valid, req_addr, req_burst,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_burst,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module : sprite_rom_arbiter
// Brief  : Round-robin arbiter with burst lock in front of a shared sprite
//          ROM (1-cycle read latency), one beat per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4
) (
  input  logic                 vga_clk,
  input  logic                 Reset,
  sprite_rom_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]    rom_address,
  input  logic [DATA_W-1:0]    rom_q,
  output logic                 busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [0:0] C_ST_IDLE   = 1'b0;
  localparam logic [0:0] C_ST_LOCKED = 1'b1;

  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [0:0]          state_q,     state_d;
  logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [PTR_W-1:0]    owner_q,     owner_d;
  logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic                gnt_any;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
      assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= C_ST_IDLE;
      rr_ptr_q    <= C_LAST_IDX;
      owner_q     <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant selection and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Grants are suppressed while reset is held so nothing is accepted then.
    if (!Reset) begin
      if (state_q == C_ST_LOCKED) begin
        gnt_any = bus.req_valid[owner_q];
        gnt_idx = owner_q;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = int'(rr_ptr_q) + k;
          if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
          end
          if (!gnt_any && bus.req_valid[j]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(j);
          end
        end
      end
    end
    gnt_onehot = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    rom_addr_d  = rom_addr_q;
    rsp_valid_d = gnt_onehot;
    if (gnt_any) begin
      rr_ptr_d   = gnt_idx;
      rom_addr_d = addr_arr[gnt_idx];
      case (state_q)
        C_ST_IDLE: begin
          if (bus.req_burst[gnt_idx]) begin
            state_d = C_ST_LOCKED;
            owner_d = gnt_idx;
          end
        end
        C_ST_LOCKED: begin
          if (!bus.req_burst[gnt_idx]) begin
            state_d = C_ST_IDLE;
          end
        end
        default: state_d = C_ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = gnt_onehot;
    rom_address   = gnt_any ? addr_arr[gnt_idx] : rom_addr_q;
    bus.rsp_valid = rsp_valid_q;
    // The ROM word in this cycle belongs to the beat accepted last cycle.
    bus.rsp_data  = (|rsp_valid_q) ? rom_q : '0;
    busy          = (state_q == C_ST_LOCKED);
  end

  a_ready_onehot : assert property (@(posedge vga_clk) disable iff (Reset)
    $onehot0(bus.req_ready));
  a_ready_valid  : assert property (@(posedge vga_clk) disable iff (Reset)
    (bus.req_ready & ~bus.req_valid) == '0);
  a_ptr_range    : assert property (@(posedge vga_clk) disable iff (Reset)
    int'(rr_ptr_q) < NUM_REQ);

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// Module : tb_sprite_rom_arbiter
// Brief  : Scoreboard bench for sprite_rom_arbiter: directed vectors plus a
//          model-driven random stretch.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_rom_arbiter;

  typedef struct {
    int         idx;
    logic [9:0] addr;
    logic [3:0] data;
  } exp_t;

  logic       vga_clk;
  logic       Reset;
  logic [9:0] rom_address;
  logic [3:0] rom_q;
  logic       busy;

  exp_t gnt_q[$];
  exp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_locked;
  int         m_owner;
  int         m_rr;
  logic [9:0] last_addr;

  sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(4)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(4)) dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .bus         (bus),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .busy        (busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_fn(input logic [9:0] a);
    return a[3:0] + a[7:4];
  endfunction

  // Synchronous ROM model: data appears one cycle after the address is sampled
  always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a response
  always @(negedge vga_clk) begin
    exp_t e;
    chk("ready_onehot_valid",
        32'(($onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == 3'b000)) ? 1 : 0), 32'd1);
    if (bus.req_ready != 3'b000) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_grant", 32'(bus.req_ready), 32'd0);
      end else begin
        e = gnt_q.pop_front();
        chk("grant", 32'(bus.req_ready), 32'd1 << e.idx);
        chk("rom_address", 32'(rom_address), 32'(e.addr));
      end
    end
    if (bus.rsp_valid != 3'b000) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.idx);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      end
    end
  end

  // Called at posedge+1; releases reset at the following posedge+1.
  task automatic do_reset(input logic [2:0] v);
    bus.req_valid = v;
    bus.req_burst = 3'b000;
    Reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    gnt_q.delete();
    rsp_q.delete();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_rr      = 2;
    last_addr = '0;
    @(posedge vga_clk);
    #1;
    Reset = 1'b0;
  endtask

  // One cycle of stimulus. exp_arg = -2 takes the grant from the model,
  // exp_busy_arg < 0 takes busy from the model.
  task automatic drive(input logic [2:0] v, input logic [2:0] b,
                       input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                       input int exp_arg, input int exp_busy_arg);
    logic [9:0] a [3];
    int m_idx;
    int e;
    int eb;
    a[0] = a0; a[1] = a1; a[2] = a2;
    m_idx = -1;
    if (m_locked) begin
      if (v[m_owner]) m_idx = m_owner;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int j;
        j = (m_rr + k) % 3;
        if (m_idx < 0 && v[j]) m_idx = j;
      end
    end
    e  = (exp_arg == -2) ? m_idx : exp_arg;
    eb = (exp_busy_arg < 0) ? int'(m_locked) : exp_busy_arg;

    bus.req_valid = v;
    bus.req_burst = b;
    bus.req_addr  = {a2, a1, a0};
    if (e >= 0) gnt_q.push_back('{e, a[e], rom_fn(a[e])});

    @(negedge vga_clk);
    #1;
    if (gnt_q.size() != 0) begin
      chk("grant_missing", 32'(bus.req_ready), 32'd1 << e);
      gnt_q.delete();
    end
    if (rsp_q.size() != 0) begin
      chk("rsp_missing", 32'(bus.rsp_valid), 32'd1 << rsp_q[0].idx);
      rsp_q.delete();
    end
    chk("busy", 32'(busy), 32'(eb));
    if (e < 0) chk("rom_address_hold", 32'(rom_address), 32'(last_addr));
    else begin
      last_addr = a[e];
      rsp_q.push_back('{e, a[e], rom_fn(a[e])});
    end

    if (e >= 0) begin
      m_rr = e;
      if (!m_locked) begin
        if (b[e]) begin
          m_locked = 1'b1;
          m_owner  = e;
        end
      end else if (!b[e]) begin
        m_locked = 1'b0;
      end
    end
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset         = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_burst = 3'b000;
    bus.req_addr  = '0;
    @(posedge vga_clk);
    #1;
    do_reset(3'b111);

    // Single request from 0 at 0x025; ROM word there is 0x7
    drive(3'b001, 3'b000, 10'h025, 10'h140, 10'h2A3, 0, 0);
    drive(3'b000, 3'b000, 10'h025, 10'h140, 10'h2A3, -1, 0);

    // All valid, no burst, starting from reset pointer: 0,1,2,0,1,2
    do_reset(3'b000);
    for (int k = 0; k < 6; k++)
      drive(3'b111, 3'b000, 10'h010 + 10'(k), 10'h150 + 10'(k), 10'h290 + 10'(k), k % 3, 0);

    // Put rr_ptr on 0 so requester 1 wins, then a 32-beat burst
    drive(3'b001, 3'b000, 10'h300, 10'h000, 10'h200, 0, 0);
    for (int k = 0; k < 32; k++)
      drive(3'b111, (k < 31) ? 3'b010 : 3'b000, 10'h300, 10'h020 + 10'(k), 10'h200, 1, (k == 0) ? 0 : 1);
    drive(3'b111, 3'b000, 10'h300, 10'h040, 10'h201, 2, 0);

    // Owner 1 pauses for 3 cycles while 0 waits, then finishes
    drive(3'b010, 3'b010, 10'h0AA, 10'h111, 10'h222, 1, 0);
    repeat (3) drive(3'b001, 3'b010, 10'h0AA, 10'h112, 10'h222, -1, 1);
    drive(3'b011, 3'b010, 10'h0AA, 10'h113, 10'h222, 1, 1);
    drive(3'b011, 3'b000, 10'h0AA, 10'h114, 10'h222, 1, 1);
    drive(3'b011, 3'b000, 10'h0AB, 10'h115, 10'h222, 0, 0);

    // Reset in the middle of a burst with a response in flight
    drive(3'b100, 3'b100, 10'h055, 10'h066, 10'h3C1, 2, 0);
    drive(3'b100, 3'b100, 10'h055, 10'h066, 10'h3C2, 2, 1);
    do_reset(3'b111);
    drive(3'b111, 3'b000, 10'h0F0, 10'h0F1, 10'h0F2, 0, 0);
    drive(3'b000, 3'b000, 10'h0F0, 10'h0F1, 10'h0F2, -1, 0);

    // Random valid/burst traffic against the reference model
    for (int k = 0; k < 1500; k++)
      drive(3'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            10'($urandom), 10'($urandom), 10'($urandom), -2, -1);
    drive(3'b000, 3'b000, 10'h000, 10'h000, 10'h000, -1, -1);

    chk("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
